// File: rtl/tsense_pkg.sv
// tsense_pkg -- shared definitions for the LM07 temperature display.
//   FSM state encoding, 4-bit glyph codes, active-low 7-segment patterns
//   ({g,f,e,d,c,b,a}), digit-select codes and the double-dabble adjust step.
package tsense_pkg;

   typedef logic [3:0] glyph_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Glyph codes 0-9 are the digit values themselves.
   localparam glyph_t G_MINUS = 4'hA;
   localparam glyph_t G_BLANK = 4'hF;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [1:0] DISP_UNITS = 2'b10;
   localparam logic [1:0] DISP_TENS  = 2'b01;
   localparam logic [1:0] DISP_NONE  = 2'b11;

   // Double-dabble correction applied to each BCD nibble before a shift.
   function automatic logic [3:0] dabble_adj(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/tsense_disp_seg7_decode.sv
// seg7_decode -- combinational glyph to active-low segment decoder.
//   glyph : 4-bit glyph code (0-9, G_MINUS, G_BLANK)
//   seg   : active-low segments {g,f,e,d,c,b,a}; unknown codes are blank
module seg7_decode
   import tsense_pkg::*;
(
   input  logic [3:0] glyph,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (glyph)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         G_MINUS: seg = SEG_MINUS;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/tsense_disp.sv
// tsense_disp -- two-digit multiplexed 7-segment display of an LM07 reading.
//   SYSCLK  : system clock, rising edge
//   RSTN    : synchronous active-low reset
//   TEMP    : raw LM07 word, signed temperature in [15:3], 0.0625 C/LSB
//   TVALID  : one-cycle strobe qualifying TEMP (ignored while BUSY)
//   disp    : active-low digit select, 10 = units, 01 = tens, 11 = none
//   dataSeg : active-low segments {dp,g,f,e,d,c,b,a} for the selected digit
//   OVR     : displayed value is outside -9..99
//   BUSY    : conversion in progress (LOAD, SHIFT, DONE)
module tsense_disp
   import tsense_pkg::*;
#(
   parameter int REFRESH_DIV = 25000
) (
   input  logic        SYSCLK,
   input  logic        RSTN,
   input  logic [15:0] TEMP,
   input  logic        TVALID,
   output logic [1:0]  disp,
   output logic [7:0]  dataSeg,
   output logic        OVR,
   output logic        BUSY
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] presc;
   logic [1:0]    state;
   logic [9:0]    temp_q;     // TEMP[15:6]: integer degrees plus half-degree bit
   logic          neg_q;
   logic          oor_q;
   logic [6:0]    bin_q;
   logic [7:0]    bcd_q;
   logic [2:0]    cnt_q;
   glyph_t        tens_q;
   glyph_t        units_q;
   logic          dp_q;
   logic          blank_q;

   logic          unused_lsbs;
   assign unused_lsbs = ^TEMP[5:0];

   // Scan: leaving reset, the units digit is selected with the prescaler held
   // at 0, so every selection lasts exactly REFRESH_DIV cycles.
   always_ff @(posedge SYSCLK) begin
      if (!RSTN) begin
         presc <= '0;
         disp  <= DISP_NONE;
      end else if (disp == DISP_NONE) begin
         presc <= '0;
         disp  <= DISP_UNITS;
      end else if (presc == PRESC_MAX) begin
         presc <= '0;
         disp  <= ~disp;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Sign, magnitude and range of the captured reading.
   logic [8:0] deg;
   logic [8:0] mag9;
   logic       deg_neg;
   logic       deg_oor;
   logic [7:0] bcd_adj;

   always_comb begin
      deg     = temp_q[9:1];
      deg_neg = deg[8];
      mag9    = deg_neg ? (9'd0 - deg) : deg;
      deg_oor = deg_neg ? (mag9 > 9'd9) : (mag9 > 9'd99);
      bcd_adj = {dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};
   end

   always_ff @(posedge SYSCLK) begin
      if (!RSTN) begin
         state   <= ST_IDLE;
         temp_q  <= '0;
         neg_q   <= 1'b0;
         oor_q   <= 1'b0;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         tens_q  <= G_BLANK;
         units_q <= G_BLANK;
         dp_q    <= 1'b0;
         OVR     <= 1'b0;
         blank_q <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (TVALID) begin
                  temp_q <= TEMP[15:6];
                  state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               neg_q <= deg_neg;
               oor_q <= deg_oor;
               bin_q <= mag9[6:0];
               bcd_q <= '0;
               cnt_q <= '0;
               state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               bcd_q <= {bcd_adj[6:0], bin_q[6]};
               bin_q <= {bin_q[5:0], 1'b0};
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd6) state <= ST_DONE;
            end
            default: begin
               OVR     <= oor_q;
               blank_q <= 1'b0;
               dp_q    <= temp_q[0] & ~oor_q;
               if (oor_q) begin
                  tens_q  <= G_MINUS;
                  units_q <= G_MINUS;
               end else if (neg_q) begin
                  tens_q  <= G_MINUS;
                  units_q <= bcd_q[3:0];
               end else begin
                  tens_q  <= (bcd_q[7:4] == 4'd0) ? G_BLANK : bcd_q[7:4];
                  units_q <= bcd_q[3:0];
               end
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign BUSY = (state != ST_IDLE);

   // Single decoder shared by both digits through the select mux.
   glyph_t     glyph_sel;
   logic [6:0] seg;
   logic       dp_n;

   always_comb begin
      glyph_sel = G_BLANK;
      if (!blank_q) begin
         if (disp == DISP_UNITS)     glyph_sel = units_q;
         else if (disp == DISP_TENS) glyph_sel = tens_q;
      end
      dp_n = ~((disp == DISP_UNITS) & dp_q & ~blank_q);
   end

   seg7_decode u_seg7 (
      .glyph (glyph_sel),
      .seg   (seg)
   );

   assign dataSeg = {dp_n, seg};

endmodule

// File: doc/tsense_disp.md
TSENSE_DISP -- requirements
Module: tsense_disp

Interface
REQ-001 Parameter: REFRESH_DIV, default 25000, meaning SYSCLK cycles each digit stays selected (>=2).
REQ-002 SYSCLK  input  1  system clock, 50 MHz nominal, all logic on rising edge.
REQ-003 RSTN  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 TEMP  input  16  raw LM07 word from the SPI read stage: signed temperature in [15:3], 0.0625 C/LSB.
REQ-005 TVALID  input  1  one-cycle strobe; TEMP is valid in that cycle.
REQ-006 disp  output  2  active-low digit select: 2'b10 = units digit, 2'b01 = tens digit, 2'b11 = none.
REQ-007 dataSeg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-008 OVR  output  1  high while the displayed value is out of range.
REQ-009 BUSY  output  1  high while a conversion is in progress.

Function
REQ-010 Integer degrees SHALL be TEMP[15:7] as 9-bit two's complement, rounded toward minus infinity.
REQ-011 FSM states SHALL be IDLE, LOAD, SHIFT, DONE; reset enters IDLE.
REQ-012 IDLE -> LOAD on TVALID=1; TEMP is captured in the same cycle.
REQ-013 LOAD: compute sign, 7-bit magnitude, and range flag; clear BCD; -> SHIFT.
REQ-014 SHIFT: run double-dabble for exactly 7 cycles, adding 3 to any BCD nibble >=5 before each shift; -> DONE.
REQ-015 DONE: update display registers in a single cycle; -> IDLE.
REQ-016 Latency: display registers SHALL change 9 cycles after the TVALID cycle. BUSY SHALL be high in LOAD, SHIFT and DONE.
REQ-017 TVALID SHALL be ignored while BUSY=1. No queueing.
REQ-018 Value 0..99: tens digit shown; leading zero blanked when value <10. OVR=0.
REQ-019 Value -1..-9: tens shows '-', units shows magnitude. OVR=0.
REQ-020 Value >99 or < -9: both digits show '-'. OVR=1.
REQ-021 dp SHALL light on the units digit only when captured TEMP[6]=1 (half-degree). It SHALL never light on the tens digit or when OVR=1.
REQ-022 Scan: a prescaler counts 0..REFRESH_DIV-1. On wrap, disp toggles between 2'b10 and 2'b01. The first selection after reset is 2'b10.
REQ-023 dataSeg SHALL always correspond to the digit currently selected by disp in the same cycle.
REQ-024 Scanning SHALL continue during conversion. The old display value is held until DONE.

Reset
REQ-025 While RSTN=0 at a clock edge: disp=2'b11, dataSeg=8'hFF, OVR=0, BUSY=0, prescaler=0, FSM=IDLE.
REQ-026 After reset, the blank flag SHALL be set, so both digits show 8'hFF until the first DONE; disp scans normally.
REQ-027 Reset asserted mid-conversion SHALL abort it, with no display update.

Structure
REQ-028 The shared package tsense_pkg SHALL hold the FSM state encoding, the 4-bit glyph codes (0-9, MINUS, BLANK) and the 7-segment constants.
REQ-029 The sub-module seg7_decode SHALL be purely combinational, mapping a 4-bit glyph code to the active-low 7-bit segments.
REQ-030 The block SHALL instantiate exactly one seg7_decode, fed by a digit mux.

Verification (REFRESH_DIV=4)
REQ-031 TEMP=16'h0B9F, TVALID pulse -> 9 cycles later: tens dataSeg=8'hA4, units=8'hB0, dp off, OVR=0.
REQ-032 TEMP=16'hFC80 (-7) -> tens=8'hBF, units=8'hF8, OVR=0.
REQ-033 TEMP=16'h3200 (100) -> both digits=8'hBF, OVR=1. TEMP=16'h00C0 -> tens=8'hFF, units=8'hF9 with dp low (8'h79).
REQ-034 TVALID with 16'h0B9F, then a second TVALID with 16'h3200 three cycles later -> display 23, OVR=0, second strobe ignored.
REQ-035 RSTN=0 at cycle 4 of SHIFT -> next edge: disp=2'b11, dataSeg=8'hFF, BUSY=0. After release, digits stay blank.
REQ-036 Idle scan -> disp sequence is 10,10,10,10,01,01,01,01,10..., and no BUSY activity.
